// File: rtl/dual_port_ram_be_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dpram_pkg                                                  |
// | Purpose : Shared types, constants and byte-merge helper for          |
// |           dual_port_ram_be.                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dpram_pkg;

   localparam int c_max_data_width = 256;
   localparam int c_max_be_width   = c_max_data_width / 8;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } dpram_state_t;

   // Callers zero-extend narrower words in and truncate the result back out.
   function automatic logic [c_max_data_width-1:0] be_merge(
      input logic [c_max_data_width-1:0] old_word,
      input logic [c_max_data_width-1:0] new_word,
      input logic [c_max_be_width-1:0]   be
   );
      logic [c_max_data_width-1:0] w_res;
      w_res = old_word;
      for (int i = 0; i < c_max_be_width; i++) begin
         if (be[i]) w_res[8*i +: 8] = new_word[8*i +: 8];
      end
      return w_res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dual_port_ram_be_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dual_port_ram_be_if                                        |
// | Purpose : One RAM port: request, byte enables, data and read strobe. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface dual_port_ram_be_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
);
   logic                    en;
   logic                    we;
   logic [DATA_WIDTH/8-1:0] be;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   din;
   logic [DATA_WIDTH-1:0]   dout;
   logic                    dvalid;

   modport master (output en, we, be, addr, din, input dout, dvalid);
   modport slave  (input en, we, be, addr, din, output dout, dvalid);
endinterface
`default_nettype wire

// File: rtl/dual_port_ram_be_rd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dpram_rd_pipe                                              |
// | Purpose : LATENCY-deep read data/valid pipeline; flushed on reset,   |
// |           output data holds between strobes.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dpram_rd_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 1
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  i_valid,
   input  wire logic [DATA_WIDTH-1:0] i_data,
   output logic                       o_valid,
   output logic [DATA_WIDTH-1:0]      o_data
);

   logic                  w_last_valid;
   logic [DATA_WIDTH-1:0] w_last_data;

   generate
      if (LATENCY <= 1) begin : g_lat1
         assign w_last_valid = i_valid;
         assign w_last_data  = i_data;
      end else begin : g_latn
         logic [LATENCY-2:0]    r_v_sr;
         logic [DATA_WIDTH-1:0] r_d_sr [LATENCY-1];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_v_sr <= '0;
            end else begin
               r_v_sr[0] <= i_valid;
               for (int i = 1; i < LATENCY - 1; i++) r_v_sr[i] <= r_v_sr[i-1];
            end
         end

         always_ff @(posedge clk) begin
            r_d_sr[0] <= i_data;
            for (int i = 1; i < LATENCY - 1; i++) r_d_sr[i] <= r_d_sr[i-1];
         end

         assign w_last_valid = r_v_sr[LATENCY-2];
         assign w_last_data  = r_d_sr[LATENCY-2];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         o_valid <= w_last_valid;
         if (w_last_valid) o_data <= w_last_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dual_port_ram_be.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dual_port_ram_be                                           |
// | Purpose : True dual-port RAM with byte enables, post-reset clear,    |
// |           collision flag; DPRAM_COLL_CNT_EN adds collision counter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dual_port_ram_be
   import dpram_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 6,
   parameter int READ_LATENCY = 1,
   parameter int RDW_MODE     = 0
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   output logic               init_done,
   dual_port_ram_be_if.slave  port_a,
   dual_port_ram_be_if.slave  port_b,
   output logic               coll_err
`ifdef DPRAM_COLL_CNT_EN
   ,
   output logic [15:0]        coll_cnt
`endif
);

   localparam int c_depth = 2 ** ADDR_WIDTH;
   localparam int c_be_w  = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(c_depth - 1);

   function automatic logic [DATA_WIDTH-1:0] merge_w(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [c_be_w-1:0]     be
   );
      return DATA_WIDTH'(be_merge(c_max_data_width'(old_word),
                                  c_max_data_width'(new_word),
                                  c_max_be_width'(be)));
   endfunction

   logic [DATA_WIDTH-1:0] r_mem [c_depth];
   dpram_state_t          r_state;
   dpram_state_t          w_state_next;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic                  w_clear_we;
   logic                  w_active;
   logic                  r_coll;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_CLEAR;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_CLEAR: if (r_ptr == c_last_addr) w_state_next = ST_READY;
         ST_READY: w_state_next = ST_READY;
         default:  w_state_next = ST_CLEAR;
      endcase
   end

   always_comb begin
      init_done  = (r_state == ST_READY);
      w_clear_we = rst_n && (r_state == ST_CLEAR);
      w_active   = rst_n && (r_state == ST_READY);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)          r_ptr <= '0;
      else if (w_clear_we) r_ptr <= r_ptr + 1'b1;
   end

   logic                  w_wr_a, w_wr_b, w_rd_a, w_rd_b, w_same_addr;
   logic [DATA_WIDTH-1:0] w_new_a, w_new_b, w_base_a, w_rdata_a, w_rdata_b;

   assign w_wr_a      = w_active && port_a.en && port_a.we;
   assign w_wr_b      = w_active && port_b.en && port_b.we;
   assign w_rd_a      = w_active && port_a.en && !port_a.we;
   assign w_rd_b      = w_active && port_b.en && !port_b.we;
   assign w_same_addr = (port_a.addr == port_b.addr);

   // A is merged on top of B's result so A owns every byte it enables.
   assign w_new_b  = merge_w(r_mem[port_b.addr], port_b.din, port_b.be);
   assign w_base_a = (w_wr_b && w_same_addr) ? w_new_b : r_mem[port_a.addr];
   assign w_new_a  = merge_w(w_base_a, port_a.din, port_a.be);

   assign w_rdata_a = (RDW_MODE == RDW_NEW && w_wr_b && w_same_addr) ? w_new_b : r_mem[port_a.addr];
   assign w_rdata_b = (RDW_MODE == RDW_NEW && w_wr_a && w_same_addr) ? w_new_a : r_mem[port_b.addr];

   always_ff @(posedge clk) begin
      if (w_clear_we) begin
         r_mem[r_ptr] <= '0;
      end else begin
         if (w_wr_b) r_mem[port_b.addr] <= w_new_b;
         if (w_wr_a) r_mem[port_a.addr] <= w_new_a;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_coll <= 1'b0;
      else        r_coll <= w_wr_a && w_wr_b && w_same_addr && (|(port_a.be & port_b.be));
   end
   assign coll_err = r_coll;

`ifdef DPRAM_COLL_CNT_EN
   logic [15:0] r_coll_cnt;
   always_ff @(posedge clk) begin
      if (!rst_n)                              r_coll_cnt <= '0;
      else if (r_coll && r_coll_cnt != 16'hFFFF) r_coll_cnt <= r_coll_cnt + 16'd1;
   end
   assign coll_cnt = r_coll_cnt;
`endif

   dpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_rd_pipe_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_rd_a),
      .i_data  (w_rdata_a),
      .o_valid (port_a.dvalid),
      .o_data  (port_a.dout)
   );

   dpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_rd_pipe_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_rd_b),
      .i_data  (w_rdata_b),
      .o_valid (port_b.dvalid),
      .o_data  (port_b.dout)
   );

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_be.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_dual_port_ram_be                                        |
// | Purpose : Two DUTs (latency 1/old-data, latency 2/new-data) driven   |
// |           identically and compared with a word-level RAM model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dual_port_ram_be;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int NCYC  = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        en_a, we_a, en_b, we_b;
   logic [1:0]  be_a, be_b;
   logic [3:0]  addr_a, addr_b;
   logic [15:0] din_a, din_b;

   dual_port_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ia0 ();
   dual_port_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ib0 ();
   dual_port_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ia1 ();
   dual_port_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ib1 ();

   assign ia0.en = en_a; assign ia0.we = we_a; assign ia0.be = be_a; assign ia0.addr = addr_a; assign ia0.din = din_a;
   assign ia1.en = en_a; assign ia1.we = we_a; assign ia1.be = be_a; assign ia1.addr = addr_a; assign ia1.din = din_a;
   assign ib0.en = en_b; assign ib0.we = we_b; assign ib0.be = be_b; assign ib0.addr = addr_b; assign ib0.din = din_b;
   assign ib1.en = en_b; assign ib1.we = we_b; assign ib1.be = be_b; assign ib1.addr = addr_b; assign ib1.din = din_b;

   logic        init_o [2];
   logic        coll_o [2];
   logic        dv_o   [4];
   logic [15:0] do_o   [4];
`ifdef DPRAM_COLL_CNT_EN
   logic [15:0] cnt_o  [2];
`endif

   dual_port_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .RDW_MODE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .init_done(init_o[0]), .port_a(ia0), .port_b(ib0), .coll_err(coll_o[0])
`ifdef DPRAM_COLL_CNT_EN
      , .coll_cnt(cnt_o[0])
`endif
   );

   dual_port_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .RDW_MODE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .init_done(init_o[1]), .port_a(ia1), .port_b(ib1), .coll_err(coll_o[1])
`ifdef DPRAM_COLL_CNT_EN
      , .coll_cnt(cnt_o[1])
`endif
   );

   assign dv_o[0] = ia0.dvalid; assign do_o[0] = ia0.dout;
   assign dv_o[1] = ib0.dvalid; assign do_o[1] = ib0.dout;
   assign dv_o[2] = ia1.dvalid; assign do_o[2] = ia1.dout;
   assign dv_o[3] = ib1.dvalid; assign do_o[3] = ib1.dout;

   // Reference model: word array, readiness flag and per-port expected strobes by cycle.
   logic [15:0] mem_m [DEPTH];
   bit          ready_m;
   int          clr_m;
   bit          coll_m;
   logic [15:0] cnt_m;
   bit          exp_v [4][NCYC];
   logic [15:0] exp_d [4][NCYC];
   logic [15:0] last_m [4];
   int          rl_m  [2] = '{1, 2};
   int          rdw_m [2] = '{0, 1};

   int cyc, checks, failures;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [15:0] merge_m(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
      logic [15:0] r;
      r = o;
      for (int i = 0; i < 2; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   task automatic model_edge();
      int k;
      bit wa, wb;
      k  = cyc + 1;
      wa = en_a && we_a;
      wb = en_b && we_b;
      if (!rst_n) begin
         ready_m = 0; clr_m = 0; coll_m = 0; cnt_m = '0;
         for (int p = 0; p < 4; p++) begin
            last_m[p] = '0;
            for (int j = k; j < k + 3; j++) exp_v[p][j] = 0;
         end
      end else if (!ready_m) begin
         coll_m = 0;
         clr_m++;
         if (clr_m == DEPTH) begin
            ready_m = 1;
            for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (en_a && !we_a) begin
               exp_v[2*d][k+rl_m[d]-1] = 1;
               exp_d[2*d][k+rl_m[d]-1] = (rdw_m[d] == 1 && wb && addr_a == addr_b) ?
                                         merge_m(mem_m[addr_a], din_b, be_b) : mem_m[addr_a];
            end
            if (en_b && !we_b) begin
               exp_v[2*d+1][k+rl_m[d]-1] = 1;
               exp_d[2*d+1][k+rl_m[d]-1] = (rdw_m[d] == 1 && wa && addr_a == addr_b) ?
                                           merge_m(mem_m[addr_b], din_a, be_a) : mem_m[addr_b];
            end
         end
         coll_m = wa && wb && (addr_a == addr_b) && ((be_a & be_b) != 2'b00);
         if (coll_m && cnt_m != 16'hFFFF) cnt_m++;
         if (wb) mem_m[addr_b] = merge_m(mem_m[addr_b], din_b, be_b);
         if (wa) mem_m[addr_a] = merge_m(mem_m[addr_a], din_a, be_a);
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("init_done_d%0d", d), 32'(init_o[d]), 32'(ready_m));
         chk($sformatf("coll_err_d%0d", d), 32'(coll_o[d]), 32'(coll_m));
`ifdef DPRAM_COLL_CNT_EN
         chk($sformatf("coll_cnt_d%0d", d), 32'(cnt_o[d]), 32'(cnt_m));
`endif
      end
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("dvalid_p%0d", p), 32'(dv_o[p]), 32'(exp_v[p][cyc]));
         if (exp_v[p][cyc]) last_m[p] = exp_d[p][cyc];
         chk($sformatf("dout_p%0d", p), 32'(do_o[p]), 32'(last_m[p]));
      end
   endtask

   task automatic tick();
      if (cyc + 4 >= NCYC) begin
         $display("FAIL cycle_budget observed=%0d required<%0d", cyc, NCYC - 4);
         $fatal(1);
      end
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      check_all();
   endtask

   task automatic idle();
      en_a = 0; we_a = 0; be_a = '0; addr_a = '0; din_a = '0;
      en_b = 0; we_b = 0; be_b = '0; addr_b = '0; din_b = '0;
   endtask

   task automatic wr_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      en_a = 1; we_a = 1; addr_a = a; din_a = d; be_a = be;
   endtask

   task automatic wr_b(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      en_b = 1; we_b = 1; addr_b = a; din_b = d; be_b = be;
   endtask

   task automatic rd_a(input logic [3:0] a);
      en_a = 1; we_a = 0; addr_a = a; din_a = 16'($urandom); be_a = 2'($urandom);
   endtask

   task automatic rd_b(input logic [3:0] a);
      en_b = 1; we_b = 0; addr_b = a; din_b = 16'($urandom); be_b = 2'($urandom);
   endtask

   task automatic rand_ports(input int amax);
      en_a = ($urandom_range(0, 3) != 0); we_a = 1'($urandom); be_a = 2'($urandom);
      addr_a = 4'($urandom_range(0, amax)); din_a = 16'($urandom);
      en_b = ($urandom_range(0, 3) != 0); we_b = 1'($urandom); be_b = 2'($urandom);
      addr_b = 4'($urandom_range(0, amax)); din_b = 16'($urandom);
   endtask

   task automatic wait_init(input int exp_n);
      int n;
      n = 0;
      while (init_o[0] !== 1'b1 && n < 64) begin
         rand_ports(15);
         tick();
         n++;
      end
      chk("init_latency", 32'(n), 32'(exp_n));
      idle();
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0;
      ready_m = 0; clr_m = 0; coll_m = 0; cnt_m = '0;
      for (int p = 0; p < 4; p++) last_m[p] = '0;
      rst_n = 1'b0;
      idle();
      repeat (3) tick();

      rst_n = 1'b1;
      wait_init(16);

      for (int a = 0; a < DEPTH; a++) begin
         rd_a(4'(a)); rd_b(4'(15 - a)); tick();
      end
      idle(); repeat (3) tick();

      wr_a(4'd4, 16'hAABB, 2'b11); tick();
      idle(); rd_b(4'd4); tick();
      chk("rd4_lat1", 32'(do_o[1]), 32'h0000AABB);
      idle(); tick();
      chk("rd4_lat2", 32'(do_o[3]), 32'h0000AABB);
      repeat (2) tick();

      wr_a(4'd6, 16'h1234, 2'b01); tick();
      idle(); rd_a(4'd6); tick();
      chk("rd6_be01", 32'(do_o[0]), 32'h00000034);
      idle(); repeat (3) tick();

      wr_a(4'd2, 16'h1111, 2'b11); tick();
      wr_a(4'd2, 16'h2222, 2'b11); rd_b(4'd2); tick();
      chk("rdw_old", 32'(do_o[1]), 32'h00001111);
      idle(); tick();
      chk("rdw_new", 32'(do_o[3]), 32'h00002222);
      repeat (2) tick();

      wr_a(4'd9, 16'hAAAA, 2'b10); wr_b(4'd9, 16'hBBBB, 2'b11); tick();
      idle(); tick();
      rd_a(4'd9); tick();
      chk("dual_wr9", 32'(do_o[0]), 32'h0000AABB);
      idle(); repeat (2) tick();

      wr_a(4'd9, 16'h5555, 2'b01); wr_b(4'd9, 16'h6666, 2'b01); tick();
      chk("coll_pulse", 32'(coll_o[0]), 32'h1);
      idle(); tick();
      chk("coll_clear", 32'(coll_o[0]), 32'h0);
      wr_a(4'd10, 16'h1200, 2'b10); wr_b(4'd10, 16'h0034, 2'b01); tick();
      idle(); rd_a(4'd10); rd_b(4'd9); tick();
      idle(); repeat (3) tick();

      repeat (300) begin
         rand_ports(3);
         tick();
      end
      idle(); repeat (3) tick();

      rd_b(4'd3); rd_a(4'd5); tick();
      idle(); rst_n = 1'b0; tick();
      chk("flush_dvalid_b_lat2", 32'(dv_o[3]), 32'h0);
      chk("reset_init_done", 32'(init_o[1]), 32'h0);
      rst_n = 1'b1;
      repeat (5) begin
         rand_ports(15);
         tick();
      end
      idle(); rst_n = 1'b0; tick();
      rst_n = 1'b1;
      wait_init(16);

      for (int a = 0; a < DEPTH; a++) begin
         rd_a(4'(a)); rd_b(4'(a)); tick();
      end
      idle(); repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
- Next-generation true dual-port RAM, successor to the team's basic dual-port RAM.
- Adds per-byte write enables, a configurable registered read latency with a data-valid strobe, and a defined cross-port read-during-write mode.
- Detects same-address write collisions, and clears the array after reset.
- Single clock domain; used as a shared scratch buffer between two masters.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 6, address bits; DEPTH = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, cycles from accepted read to dout valid; legal values 1 or 2.
- RDW_MODE, 0, cross-port read-during-write result: 0 = old data, 1 = new data (bypass).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- init_done  out  1  high once the post-reset clear sweep has finished.
- en_a  in  1  port A request.
- we_a  in  1  port A write (1) or read (0); qualified by en_a.
- be_a  in  DATA_WIDTH/8  port A byte enables; bit i covers din_a[8i+7:8i].
- addr_a  in  ADDR_WIDTH  port A address.
- din_a  in  DATA_WIDTH  port A write data.
- dout_a  out  DATA_WIDTH  port A read data.
- dvalid_a  out  1  port A read-data strobe.
- en_b, we_b, be_b, addr_b, din_b, dout_b, dvalid_b: port B, identical to port A.
- coll_err  out  1  one-cycle pulse on a same-address dual write.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - init_done=0; dout_a/b=0; dvalid_a/b=0; coll_err=0; read pipelines flushed.
  - FSM enters CLEAR with the sweep pointer at 0.
- FSM CLEAR:
  - Writes 0 to the word at the pointer each cycle, then increments the pointer.
  - After writing word DEPTH-1, moves to READY and sets init_done=1 on the next cycle.
  - The clear takes exactly DEPTH cycles after reset release.
  - Port requests during CLEAR are ignored: no write, no dvalid.
- FSM READY: services both ports every cycle. It stays in READY until reset.
- Reset asserted mid-sweep or mid-operation restarts CLEAR from word 0 and discards any in-flight reads.
- Write (en=1, we=1): on the clock edge, updates only the bytes whose be bit is 1. be=0 is a legal no-op. A write never produces dvalid.
- Read (en=1, we=0):
  - dout and dvalid update exactly READY_LATENCY edges later, i.e. READ_LATENCY edges after the request edge.
  - dvalid is high for one cycle per read.
  - dout holds its last value when dvalid=0.
  - Back-to-back reads are fully pipelined at one per cycle per port.
- Cross-port read-during-write (same address, same cycle, one port reads while the other writes):
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the written bytes merged per be over the old word.
- Dual write to the same address in the same cycle:
  - Port A wins for bytes where be_a=1.
  - Port B's data lands only in bytes where be_a=0 and be_b=1.
  - coll_err pulses one cycle later, whenever (be_a & be_b) != 0.
- Dual read of the same address: both ports return the same data; no error.
- Addresses wrap naturally. There is no out-of-range case.

Optional Feature:
- Macro DPRAM_COLL_CNT_EN.
- Defined: adds output coll_cnt[15:0], a saturating count of coll_err pulses.
  - Resets to 0 on rst_n=0.
  - Holds at 16'hFFFF once saturated.
- Undefined: the port and its counter do not exist; coll_err is unchanged.

Decomposition:
- Shared package dpram_pkg holds:
  - the FSM state typedef (ST_CLEAR, ST_READY);
  - the RDW_OLD=0 and RDW_NEW=1 constants;
  - a function returning the byte-enable merge of new data over an old word.
- One sub-module, dpram_rd_pipe: the per-port READ_LATENCY-deep data/valid shift register with flush on reset.
  - Instantiated twice, once per port.

Test Plan (DATA_WIDTH=16, ADDR_WIDTH=4):
- Release reset, then poll init_done -> it rises exactly 16 cycles after release; reading every address returns 16'h0000.
- Port A writes addr 4 = 16'hAABB with be 2'b11; port B then reads addr 4 -> dout_b=16'hAABB with dvalid_b after READ_LATENCY cycles (run at 1 and at 2).
- Port A writes addr 6 = 16'h1234 with be 2'b01 over the cleared word -> a read of addr 6 returns 16'h0034.
- Store 16'h1111 at addr 2. In the same cycle, A writes addr 2 = 16'h2222 and B reads addr 2 -> RDW_MODE=0 gives 16'h1111, RDW_MODE=1 gives 16'h2222.
- Same-cycle writes to addr 9: A = 16'hAAAA with be 2'b10, B = 16'hBBBB with be 2'b11 -> word = 16'hAABB.
  - A second dual write with overlapping enables -> coll_err pulses once; coll_cnt=1 under DPRAM_COLL_CNT_EN.
- Assert rst_n=0 mid-sweep and while a read is in flight -> no dvalid emerges; init_done=0; the clear restarts and completes 16 cycles after release.
